// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered MIPS32 ALU control decoder with HI/LO mul/div sequencer
//
// Purpose: decodes ALUOp/funct into a registered ALU operation code. A valid/stall
// handshake connects it to the pipeline. A small FSM tracks HI/LO unit occupancy.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   valid_in      in   decode stage presents an instruction
//   stall_in      in   downstream stall request
//   alu_op[1:0]   in   main-control ALUOp
//   funct[5:0]    in   instruction funct field
//   stall_out     out  combinational; upstream holds its inputs while high
//   valid_out     out  registered; alu_control is valid
//   alu_control   out  registered ALU operation code (upper bits zero)
//   illegal_funct out  registered; qualifies valid_out
//   muldiv_start  out  registered one-cycle launch pulse for the HI/LO unit
//   hilo_busy     out  registered; HI/LO unit occupied
module alu_control_seq #(
    parameter int CTRL_W        = 4,
    parameter int MULDIV_LAT    = 8,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              stall_out,
    output logic              valid_out,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal_funct,
    output logic              muldiv_start,
    output logic              hilo_busy
);

    localparam logic [3:0] C_AND    = 4'b0000;
    localparam logic [3:0] C_OR     = 4'b0001;
    localparam logic [3:0] C_ADD    = 4'b0010;
    localparam logic [3:0] C_XOR    = 4'b0011;
    localparam logic [3:0] C_SUB    = 4'b0110;
    localparam logic [3:0] C_SLT    = 4'b0111;
    localparam logic [3:0] C_SLL    = 4'b1000;
    localparam logic [3:0] C_SRL    = 4'b1001;
    localparam logic [3:0] C_SRA    = 4'b1010;
    localparam logic [3:0] C_SLTU   = 4'b1011;
    localparam logic [3:0] C_NOR    = 4'b1100;
    localparam logic [3:0] C_MULDIV = 4'b1101;
    localparam logic [3:0] C_MFHILO = 4'b1110;

    localparam logic [7:0] LAT_M1 = 8'(MULDIV_LAT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_valid, r_illegal, r_start;
    logic [CTRL_W-1:0] r_alu_control;

    logic [3:0]        w_code;
    logic              w_illegal;
    logic [CTRL_W-1:0] w_code_ext;
    logic              w_needs_hilo;
    logic              w_stall;
    logic              w_accept;
    logic              w_start;

    // Instruction decode. Illegal encodings fall back to ADD so the datapath
    // still sees a harmless operation.
    always_comb begin
        w_code    = C_ADD;
        w_illegal = 1'b0;
        case (alu_op)
            2'b00: w_code = C_ADD;
            2'b01: w_code = C_SUB;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: w_code = C_ADD;
                    6'b100010, 6'b100011: w_code = C_SUB;
                    6'b100100: w_code = C_AND;
                    6'b100101: w_code = C_OR;
                    6'b100110: w_code = C_XOR;
                    6'b100111: w_code = C_NOR;
                    6'b101010: w_code = C_SLT;
                    6'b101011: w_code = C_SLTU;
                    6'b000000: w_code = C_SLL;
                    6'b000010: w_code = C_SRL;
                    6'b000011: w_code = C_SRA;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        if (ENABLE_MULDIV != 0) w_code    = C_MULDIV;
                        else                    w_illegal = 1'b1;
                    end
                    6'b010000, 6'b010010: begin
                        if (ENABLE_MULDIV != 0) w_code    = C_MFHILO;
                        else                    w_illegal = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_code_ext      = '0;
        w_code_ext[3:0] = w_code;
    end

    // Only HI/LO consumers wait on the busy unit. Everything else flows past it.
    assign w_needs_hilo = valid_in && (alu_op == 2'b10) &&
                          ((w_code == C_MULDIV) || (w_code == C_MFHILO));
    assign w_stall      = stall_in || (hilo_busy && w_needs_hilo);
    assign w_accept     = valid_in && !w_stall;
    assign w_start      = w_accept && (alu_op == 2'b10) && (w_code == C_MULDIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_alu_control <= '0;
            r_illegal     <= 1'b0;
            r_start       <= 1'b0;
        end else if (stall_in) begin
            r_start <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_alu_control <= w_code_ext;
            r_illegal     <= w_illegal;
            r_start       <= w_start;
        end else begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_start   <= 1'b0;
        end
    end

    // HI/LO occupancy: loading LAT-1 and leaving on cnt==0 keeps busy high for
    // exactly MULDIV_LAT cycles. The count runs regardless of stall_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = LAT_M1;
                end
            end
            S_BUSY: begin
                if (r_cnt != 8'd0) w_cnt_nxt   = r_cnt - 8'd1;
                else               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign stall_out     = w_stall;
    assign valid_out     = r_valid;
    assign alu_control   = r_alu_control;
    assign illegal_funct = r_illegal;
    assign muldiv_start  = r_start;
    assign hilo_busy     = (r_state == S_BUSY);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in, stall_in;
    logic [1:0] alu_op;
    logic [5:0] funct;

    logic       stall_out, valid_out, illegal_funct, muldiv_start, hilo_busy;
    logic [3:0] alu_control;

    logic       d2_stall_out, d2_valid_out, d2_illegal, d2_start, d2_busy;
    logic [5:0] d2_alu_control;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    alu_control_seq #(.CTRL_W(4), .MULDIV_LAT(8), .ENABLE_MULDIV(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in),
        .alu_op(alu_op), .funct(funct), .stall_out(stall_out),
        .valid_out(valid_out), .alu_control(alu_control),
        .illegal_funct(illegal_funct), .muldiv_start(muldiv_start),
        .hilo_busy(hilo_busy)
    );

    alu_control_seq #(.CTRL_W(6), .MULDIV_LAT(8), .ENABLE_MULDIV(0)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in),
        .alu_op(alu_op), .funct(funct), .stall_out(d2_stall_out),
        .valid_out(d2_valid_out), .alu_control(d2_alu_control),
        .illegal_funct(d2_illegal), .muldiv_start(d2_start),
        .hilo_busy(d2_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [1:0] op, input logic [5:0] f);
        valid_in = v;
        stall_in = s;
        alu_op   = op;
        funct    = f;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                           input logic il, input logic st, input logic bz);
        chk({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
        chk({tag, "_code"}, {4'd0, alu_control}, {4'd0, c});
        chk({tag, "_illegal"}, {7'd0, illegal_funct}, {7'd0, il});
        chk({tag, "_start"}, {7'd0, muldiv_start}, {7'd0, st});
        chk({tag, "_busy"}, {7'd0, hilo_busy}, {7'd0, bz});
    endtask

    logic [5:0] fl [13];
    logic [3:0] cl [13];

    initial begin
        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        cl = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC,
               4'h7, 4'hB, 4'h8, 4'h9, 4'hA};

        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 6'h00);
        #1;
        chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_d2_code", {2'd0, d2_alu_control}, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk_out("idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Every legal R-type funct, then the non-R ALUOps
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b0, 2'b10, fl[i]);
            #1;
            chk($sformatf("r_stall_%0d", i), {7'd0, stall_out}, 8'h00);
            tick();
            chk_out($sformatf("r_funct_%0d", i), 1'b1, cl[i], 1'b0, 1'b0, 1'b0);
            chk($sformatf("r_d2_code_%0d", i), {2'd0, d2_alu_control}, {4'd0, cl[i]});
        end
        drive(1'b1, 1'b0, 2'b00, 6'h3F);
        tick();
        chk_out("op00", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b01, 6'h3F);
        tick();
        chk_out("op01", 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);

        // Illegal funct and reserved ALUOp
        drive(1'b1, 1'b0, 2'b10, 6'h3F);
        tick();
        chk_out("ill_funct", 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 2'b11, 6'h20);
        tick();
        chk_out("ill_op11", 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 2'b10, 6'h20);
        tick();
        chk_out("bubble", 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);

        // MULT then MFLO held until the HI/LO unit frees up
        drive(1'b1, 1'b0, 2'b10, 6'h18);
        #1;
        chk("mult_stall", {7'd0, stall_out}, 8'h00);
        tick();
        chk_out("mult", 1'b1, 4'hD, 1'b0, 1'b1, 1'b1);
        chk("d2_mult_illegal", {7'd0, d2_illegal}, 8'h01);
        chk("d2_mult_start", {7'd0, d2_start}, 8'h00);
        chk("d2_mult_busy", {7'd0, d2_busy}, 8'h00);
        chk("d2_mult_code", {2'd0, d2_alu_control}, 8'h02);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 2'b10, 6'h12);
            #1;
            chk($sformatf("mflo_stall_%0d", i), {7'd0, stall_out}, 8'h01);
            tick();
            chk_out($sformatf("mflo_wait_%0d", i), 1'b0, 4'hD, 1'b0, 1'b0, (i < 7) ? 1'b1 : 1'b0);
        end
        #1;
        chk("mflo_free", {7'd0, stall_out}, 8'h00);
        tick();
        chk_out("mflo_acc", 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);

        // ADD/OR during BUSY, then downstream stall, busy expiry on schedule
        drive(1'b1, 1'b0, 2'b10, 6'h19);
        tick();
        chk_out("multu", 1'b1, 4'hD, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 2'b10, 6'h20);
        #1;
        chk("add_busy_stall", {7'd0, stall_out}, 8'h00);
        tick();
        chk_out("add_busy", 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 2'b10, 6'h25);
        tick();
        chk_out("or_busy", 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b10, 6'h20);
            #1;
            chk($sformatf("hold_stall_%0d", i), {7'd0, stall_out}, 8'h01);
            tick();
            chk_out($sformatf("hold_%0d", i), 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 2'b10, 6'h20);
        tick();
        chk_out("post_hold", 1'b0, 4'h1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("busy_last", {7'd0, hilo_busy}, 8'h01);
        tick();
        chk("busy_done", {7'd0, hilo_busy}, 8'h00);

        // Asynchronous reset three cycles into BUSY
        drive(1'b1, 1'b0, 2'b10, 6'h1A);
        tick();
        chk_out("div", 1'b1, 4'hD, 1'b0, 1'b1, 1'b1);
        chk("d2_div_illegal", {7'd0, d2_illegal}, 8'h01);
        chk("d2_div_start", {7'd0, d2_start}, 8'h00);
        drive(1'b0, 1'b0, 2'b00, 6'h00);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {7'd0, hilo_busy}, 8'h01);
        chk("d2_busy_idle", {7'd0, d2_busy}, 8'h00);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 6'h10);
        #1;
        chk("mfhi_stall", {7'd0, stall_out}, 8'h00);
        tick();
        chk_out("mfhi", 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);

        // Stall request with nothing presented still stalls
        drive(1'b0, 1'b1, 2'b00, 6'h00);
        #1;
        chk("idle_stall", {7'd0, stall_out}, 8'h01);
        chk("d2_idle_stall", {7'd0, d2_stall_out}, 8'h01);
        tick();
        drive(1'b0, 1'b0, 2'b00, 6'h00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Registered ALU control decoder for the MIPS32 execute stage. It supersedes the 3-bit ADD/SUB/AND/OR/SLT decoder and adds the following:
- parametrised control width
- the full R-type ALU set, including shifts, NOR, XOR and SLTU
- a valid/stall handshake with the pipeline
- an illegal-funct flag
- a multi-cycle MULT/DIV sequencer that tracks HI/LO occupancy and stalls dependent instructions

Parameters:
CTRL_W, 4, width of alu_control; must be >= 4; upper bits are always zero.
MULDIV_LAT, 8, cycles the HI/LO unit stays busy after a MULT/MULTU/DIV/DIVU; range 1..255.
ENABLE_MULDIV, 1, 0 makes MULT/DIV/MFHI/MFLO illegal and keeps hilo_busy at 0.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
valid_in  in  1  decode stage presents an instruction.
stall_in  in  1  downstream (execute) stall request.
alu_op  in  2  main-control ALUOp: 00 load/store, 01 branch, 10 R-type, 11 reserved.
funct  in  6  instruction funct field.
stall_out  out  1  combinational; upstream must hold alu_op/funct/valid_in.
valid_out  out  1  registered; alu_control is valid.
alu_control  out  CTRL_W  registered ALU operation code.
illegal_funct  out  1  registered; qualifies valid_out.
muldiv_start  out  1  registered one-cycle pulse that launches the HI/LO unit.
hilo_busy  out  1  registered; HI/LO unit occupied.

Behaviour:
- Codes (4 LSBs): AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011, NOR 1100, MULDIV 1101, MFHILO 1110.
- alu_op decode:
  - alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD with illegal_funct=1.
- funct decode (alu_op 10):
  - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT; 101011 SLTU.
  - 000000 SLL; 000010 SRL; 000011 SRA.
  - 011000/011001/011010/011011 MULDIV; 010000/010010 MFHILO.
  - Any other funct -> ADD, illegal_funct=1.
  - If ENABLE_MULDIV=0, MULDIV/MFHILO functs are illegal (ADD code, illegal_funct=1, no muldiv_start).
- needs_hilo = valid_in and alu_op=10 and the decoded code is MULDIV or MFHILO (legal only).
- stall_out = stall_in OR (hilo_busy AND needs_hilo). This path is combinational.
- accept = valid_in AND NOT stall_out.
- Latency: 1 cycle from accept to valid_out/alu_control.
- Register update on each edge:
  - If stall_in=1: valid_out, alu_control and illegal_funct hold; muldiv_start <= 0.
  - Else if accept: valid_out <= 1; decoded code and illegal flag are loaded; muldiv_start <= (code==MULDIV).
  - Else: valid_out <= 0, muldiv_start <= 0, illegal_funct <= 0; alu_control holds its last value.
- HI/LO FSM, states IDLE and BUSY, 8-bit down-counter cnt:
  - IDLE -> BUSY on an accepted MULDIV; cnt <= MULDIV_LAT-1; hilo_busy <= 1 (same edge as muldiv_start).
  - BUSY with cnt>0: cnt decrements every cycle, independent of stall_in.
  - BUSY with cnt=0: -> IDLE, hilo_busy <= 0.
  - Result: hilo_busy is high exactly MULDIV_LAT cycles.
- A MULDIV/MFHILO presented while hilo_busy=1 is stalled. It is accepted on the first cycle hilo_busy=0; a new MULDIV may re-enter BUSY in that same cycle.
- Non-HI/LO instructions are never stalled by BUSY.
- Reset (asynchronous, any time, including mid-BUSY):
  - valid_out=0, alu_control=0, illegal_funct=0, muldiv_start=0, hilo_busy=0, state IDLE, cnt=0.
  - An in-flight mul/div is abandoned.
- stall_in=1 with valid_in=0 still asserts stall_out.

Test Plan:
1. Reset, then valid_in=1, alu_op=10, funct=100010 -> next cycle valid_out=1, alu_control=0110, illegal_funct=0. Repeat for every legal funct, checking each code.
2. alu_op=10, funct=111111 -> alu_control=0010, illegal_funct=1, valid_out=1. Then alu_op=11 -> the same response.
3. MULT (011000) with MULDIV_LAT=8 -> muldiv_start pulses 1 cycle; hilo_busy high exactly 8 cycles. MFLO (010010) presented on the next cycle -> stall_out=1 for 8 cycles, accepted on the cycle hilo_busy=0, alu_control=1110. An ADD interleaved during BUSY -> accepted with no stall.
4. stall_in=1 held 3 cycles after an OR is accepted -> valid_out=1 and alu_control=0001 held, stall_out=1. BUSY cnt still expires on schedule.
5. Assert rst 3 cycles into BUSY -> hilo_busy=0 and all outputs 0 immediately (asynchronously). After release, MFHI is accepted without stalling.
6. ENABLE_MULDIV=0, DIV (011010) -> illegal_funct=1, muldiv_start=0, hilo_busy stays 0. CTRL_W=6 -> upper 2 bits always 0.
